// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Holds the controller state enum, default geometry and address helpers.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_e;

    localparam int DEF_ADDRESS_WIDTH  = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_SETS           = 64;
    localparam int DEF_WORDS_PER_LINE = 4;

    localparam int WORD_SEL_BITS = $clog2(DEF_WORDS_PER_LINE);
    localparam int OFFSET_BITS   = WORD_SEL_BITS + 2;
    localparam int INDEX_BITS    = $clog2(DEF_SETS);
    localparam int TAG_BITS      = DEF_ADDRESS_WIDTH - OFFSET_BITS
                                   - INDEX_BITS;

    // Generic field extractor so any geometry can slice its own
    // word-select, index and tag without per-width helpers.
    function automatic logic [63:0] addr_field(
        input logic [63:0] a,
        input int          lsb,
        input int          width
    );
        return (a >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Cache line storage: SETS x WORDS_PER_LINE words, async read, byte-strobed
// sync write. Ports: clk_i, we_i, set_i, rd_word_i, wr_word_i, be_i,
// wdata_i, rdata_o.
module dcache_data_array #(
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                              clk_i,
    input  logic                              we_i,
    input  logic [$clog2(SETS)-1:0]           set_i,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_word_i,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_word_i,
    input  logic [3:0]                        be_i,
    input  logic [DATA_WIDTH-1:0]             wdata_i,
    output logic [DATA_WIDTH-1:0]             rdata_o
);

    localparam int LANE = DATA_WIDTH / 4;

    logic [DATA_WIDTH-1:0] mem_q [SETS*WORDS_PER_LINE];

    assign rdata_o = mem_q[{set_i, rd_word_i}];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[{set_i, wr_word_i}][b*LANE +: LANE]
                        <= wdata_i[b*LANE +: LANE];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate D-cache controller (M stage).
// Ports: M-stage access (AddrM/MemReadM/MemWriteM/ByteEnM/WriteDataM),
// ReadDataM_o, CacheStall_o, word-serial memory beat handshake.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int SETS           = DEF_SETS,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDRESS_WIDTH-1:0] AddrM_i,
    input  logic                     MemReadM_i,
    input  logic                     MemWriteM_i,
    input  logic [3:0]               ByteEnM_i,
    input  logic [DATA_WIDTH-1:0]    WriteDataM_i,
    output logic [DATA_WIDTH-1:0]    ReadDataM_o,
    output logic                     CacheStall_o,
    output logic                     MemReq_o,
    output logic                     MemWe_o,
    output logic [ADDRESS_WIDTH-1:0] MemAddr_o,
    output logic [DATA_WIDTH-1:0]    MemWData_o,
    input  logic                     MemReady_i,
    input  logic [DATA_WIDTH-1:0]    MemRData_i
);

    localparam int WSEL_W = $clog2(WORDS_PER_LINE);
    localparam int OFF_W  = WSEL_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDRESS_WIDTH - OFF_W - IDX_W;
    localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(WORDS_PER_LINE - 1);

    state_e            state_q, state_d;
    logic [WSEL_W-1:0] cnt_q, cnt_d;
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q [SETS];

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [WSEL_W-1:0]     req_word;
    logic                  access;
    logic                  hit;
    logic                  victim_dirty;

    logic                  arr_we;
    logic [3:0]            arr_be;
    logic [WSEL_W-1:0]     arr_wr_word;
    logic [WSEL_W-1:0]     arr_rd_word;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic                  set_line;
    logic                  hit_store;

    assign req_word = WSEL_W'(addr_field(64'(AddrM_i), 2, WSEL_W));
    assign req_idx  = IDX_W'(addr_field(64'(AddrM_i), OFF_W, IDX_W));
    assign req_tag  = TAG_W'(addr_field(64'(AddrM_i), OFF_W + IDX_W,
                                        TAG_W));

    assign access       = MemReadM_i | MemWriteM_i;
    assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];

    // State register plus valid/dirty bookkeeping; reset clears the
    // line state even mid-miss, so an in-flight writeback is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (set_line) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
            end else if (hit_store) begin
                dirty_q[req_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (set_line && !rst_i) begin
            tag_q[req_idx] <= req_tag;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (access && !hit) begin
                    state_d = victim_dirty ? WRITEBACK : REFILL;
                    cnt_d   = '0;
                end
            end
            WRITEBACK: begin
                if (MemReady_i) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = REFILL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + WSEL_W'(1);
                    end
                end
            end
            REFILL: begin
                if (MemReady_i) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + WSEL_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        CacheStall_o = 1'b1;
        MemReq_o     = 1'b0;
        MemWe_o      = 1'b0;
        MemAddr_o    = {req_tag, req_idx, cnt_q, 2'b00};
        arr_we       = 1'b0;
        arr_be       = '0;
        arr_wr_word  = req_word;
        arr_rd_word  = req_word;
        arr_wdata    = WriteDataM_i;
        set_line     = 1'b0;
        hit_store    = 1'b0;
        unique case (state_q)
            IDLE: begin
                CacheStall_o = access && !hit;
                if (access && hit && MemWriteM_i) begin
                    arr_we    = 1'b1;
                    arr_be    = ByteEnM_i;
                    hit_store = 1'b1;
                end
            end
            WRITEBACK: begin
                MemReq_o    = 1'b1;
                MemWe_o     = 1'b1;
                MemAddr_o   = {tag_q[req_idx], req_idx, cnt_q, 2'b00};
                arr_rd_word = cnt_q;
            end
            REFILL: begin
                MemReq_o = 1'b1;
                if (MemReady_i) begin
                    arr_we      = 1'b1;
                    arr_be      = 4'hF;
                    arr_wr_word = cnt_q;
                    arr_wdata   = MemRData_i;
                    set_line    = (cnt_q == LAST_BEAT);
                end
            end
            default: begin
                CacheStall_o = 1'b0;
            end
        endcase
    end

    // Read port is shared: load data in IDLE, victim word in WRITEBACK.
    assign ReadDataM_o = arr_rdata;
    assign MemWData_o  = arr_rdata;

    dcache_data_array #(
        .SETS           (SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_data (
        .clk_i     (clk_i),
        .we_i      (arr_we & ~rst_i),
        .set_i     (req_idx),
        .rd_word_i (arr_rd_word),
        .wr_word_i (arr_wr_word),
        .be_i      (arr_be),
        .wdata_i   (arr_wdata),
        .rdata_o   (arr_rdata)
    );

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-back, write-allocate data cache controller in the Memory stage of the pipelined RV32I core. It services MemRead/MemWrite from the M stage and fills or evicts lines over a word-serial main-memory handshake. It also produces CacheStall_o, which the hazard unit uses to freeze F/D/E/M/W while a miss is serviced.

Parameters:
ADDRESS_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width
SETS, 64, number of lines (power of 2)
WORDS_PER_LINE, 4, words per line (power of 2)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
AddrM_i  input  ADDRESS_WIDTH  byte address of M-stage access
MemReadM_i  input  1  load in M stage
MemWriteM_i  input  1  store in M stage
ByteEnM_i  input  4  store byte strobes (sb/sh/sw)
WriteDataM_i  input  DATA_WIDTH  store data, pre-aligned to lanes
ReadDataM_o  output  DATA_WIDTH  full load word (extension done downstream)
CacheStall_o  output  1  to hazard unit CacheStall_i
MemReq_o  output  1  memory beat request
MemWe_o  output  1  1 = writeback beat, 0 = refill beat
MemAddr_o  output  ADDRESS_WIDTH  word-aligned beat address
MemWData_o  output  DATA_WIDTH  writeback data
MemReady_i  input  1  memory accepts/returns the beat this cycle
MemRData_i  input  DATA_WIDTH  refill data, valid when MemReq_o && MemReady_i && !MemWe_o

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Address split, default geometry: [1:0] byte, [3:2] word, [9:4] index, [31:10] tag.
- Access = MemReadM_i || MemWriteM_i. If both are high, treat as a write.
- States: IDLE, WRITEBACK, REFILL.
- IDLE, hit (valid && tag match):
  - CacheStall_o=0.
  - ReadDataM_o is combinational from the data array, same cycle.
  - A write updates the enabled bytes at the clock edge and sets dirty.
- IDLE, miss:
  - CacheStall_o=1 combinationally, same cycle.
  - Next state is WRITEBACK if the victim is valid && dirty, else REFILL.
  - Beat counter cleared.
- WRITEBACK:
  - MemReq_o=1, MemWe_o=1.
  - MemAddr_o = {victim tag, index, count, 2'b00}; MemWData_o = victim word[count].
  - Beat completes when MemReady_i=1, then count++.
  - After beat WORDS_PER_LINE-1: go to REFILL, count=0.
- REFILL:
  - MemReq_o=1, MemWe_o=0; MemAddr_o = {request tag, index, count, 2'b00}.
  - On each completed beat, write MemRData_i into word[count].
  - After the last beat: tag written, valid=1, dirty=0, return to IDLE.
  - The held request then hits and completes (store merges at that edge).
- CacheStall_o=1 in WRITEBACK and REFILL regardless of MemReady_i.
- MemReq_o=0 in IDLE. Outputs hold stable while MemReady_i=0; no beat is dropped or repeated.
- The M-stage request is frozen by the hazard unit during the stall, so the controller reads it live and does not latch it.
- Zero-wait-memory miss penalty: clean miss = 1 + WORDS_PER_LINE stall cycles; dirty miss = 1 + 2*WORDS_PER_LINE.
- No access in IDLE: CacheStall_o=0 and the arrays are unchanged. ReadDataM_o may be any value.
- Reset, including mid-miss:
  - State IDLE, count 0, MemReq_o=0, CacheStall_o=0 (once no miss is present).
  - All valid and dirty bits cleared; tag/data arrays not reset.
  - An in-flight writeback is abandoned and dirty data is lost. This is accepted.
- Beat counter wraps only via the state transition; it never exceeds WORDS_PER_LINE-1.

Decomposition:
- Package dcache_pkg:
  - state enum (IDLE, WRITEBACK, REFILL);
  - localparams OFFSET_BITS, INDEX_BITS, TAG_BITS, WORD_SEL_BITS derived from the parameters;
  - address field extraction functions.
- Sub-module dcache_data_array:
  - SETS x WORDS_PER_LINE x DATA_WIDTH storage;
  - one combinational read port;
  - one synchronous write port with 4-bit byte enables;
  - shared by hit-store and refill writes (refill uses all-ones strobes).
- Tag/valid/dirty arrays and the FSM stay in the top module.

Test Plan:
- Cold load 0x0000_0040, memory ready every cycle:
  - 5 stall cycles;
  - beats at 0x40, 0x44, 0x48, 0x4C with MemWe_o=0;
  - then ReadDataM_o = word returned on beat 0, stall low.
- Repeat the load at 0x44 right after refill → hit, CacheStall_o=0, no MemReq_o.
- sb to 0x41 with ByteEnM_i=4'b0010 and data 0x0000_AB00, then lw 0x40 → byte 1 = 0xAB, other bytes unchanged. Line is dirty, no memory traffic.
- Load 0x440 (same index, new tag) after the dirty store:
  - 4 writeback beats to 0x40..0x4C carrying the modified line;
  - then 4 refill beats from 0x440;
  - total 9 stall cycles.
- Refill with MemReady_i low for 3 cycles before each beat → MemAddr_o/MemReq_o held stable, stall extended by exactly 12 cycles, data correct.
- Assert rst_i during REFILL beat 2:
  - next cycle MemReq_o=0, state IDLE;
  - re-accessing the same address misses (valid cleared) and refills fully.
